// File: rtl/snes_pad_poller_if.sv
// Purpose : bundles the pad-side serial lines and the CPU-side control/status
//           signals of the SNES pad poller into one connection.
// Modports:
//   master - the poller: drives pad_latch/pad_clk and all status outputs,
//            receives enable, clear_pressed and the raw pad_data line.
//   slave  - the system/pad side: the mirror image of master.
// Signals :
//   enable        1 = polling allowed (looked at only while idle)
//   clear_pressed one-cycle pulse clearing the sticky pressed bits
//   pad_data      serial data from pad, active-low, asynchronous
//   pad_latch     latch strobe to pad, active-high
//   pad_clk       shift clock to pad, idles high
//   buttons       current button state, active-high
//   ctrl_word     {pressed, buttons} MMIO read value
//   new_sample    one-cycle pulse after buttons/pressed update
//   busy          high while a frame is in progress
interface snes_pad_poller_if;
  logic        enable;
  logic        clear_pressed;
  logic        pad_data;
  logic        pad_latch;
  logic        pad_clk;
  logic [15:0] buttons;
  logic [31:0] ctrl_word;
  logic        new_sample;
  logic        busy;

  modport master (
    input  enable, clear_pressed, pad_data,
    output pad_latch, pad_clk, buttons, ctrl_word, new_sample, busy
  );

  modport slave (
    output enable, clear_pressed, pad_data,
    input  pad_latch, pad_clk, buttons, ctrl_word, new_sample, busy
  );
endinterface

// File: rtl/snes_pad_poller.sv
// Purpose : polls one SNES-style serial game pad at a fixed frame rate,
//           publishes the 16 button states and sticky "newly pressed" edges
//           as a 32-bit controller word.
// Ports   :
//   clock  - system clock, all state on the rising edge
//   reset  - asynchronous, active-low reset
//   bus    - snes_pad_poller_if.master: pad lines plus control/status
// Parameters:
//   CLK_DIV     - clock cycles per half bit period (>= 4)
//   POLL_CYCLES - idle cycles between frames (>= 1)
module snes_pad_poller #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_CYCLES = 833333
) (
  input logic                clock,
  input logic                reset,
  snes_pad_poller_if.master  bus
);

  localparam int HC_W = $clog2(CLK_DIV);
  localparam int PC_W = $clog2(POLL_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETTLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hc_q, hc_d;
  logic [PC_W-1:0]   poll_q, poll_d;
  logic [3:0]        b_q, b_d;
  logic [15:0]       shreg_q, shreg_d;
  logic [15:0]       buttons_q, buttons_d;
  logic [15:0]       pressed_q, pressed_d;
  logic              new_sample_q, new_sample_d;
  logic              pad_latch_q, pad_latch_d;
  logic              pad_clk_q, pad_clk_d;
  logic              sync1_q, sync2_q;
  logic              phase_end;

  // Two-flop synchronizer for the asynchronous pad data line; resets to the
  // idle (released) level so a reset never looks like a pressed button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.pad_data;
      sync2_q <= sync1_q;
    end
  end

  assign phase_end = (hc_q == HC_W'(CLK_DIV - 1));

  // Next-state logic. The LATCH phase lasts two half periods, so the bit
  // index b doubles as the half-period counter there before being cleared
  // for the shift phase. pad_latch/pad_clk are decoded from the next state
  // so the registered pins change exactly on state entry.
  always_comb begin
    state_d      = state_q;
    hc_d         = phase_end ? '0 : hc_q + HC_W'(1);
    poll_d       = poll_q;
    b_d          = b_q;
    shreg_d      = shreg_q;
    buttons_d    = buttons_q;
    pressed_d    = bus.clear_pressed ? 16'h0000 : pressed_q;
    new_sample_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hc_d = '0;
        if (bus.enable) begin
          if (poll_q == PC_W'(POLL_CYCLES - 1)) begin
            state_d = ST_LATCH;
            poll_d  = '0;
            b_d     = 4'd0;
          end else begin
            poll_d = poll_q + PC_W'(1);
          end
        end else begin
          poll_d = '0;
        end
      end
      ST_LATCH: begin
        if (phase_end) begin
          if (b_q[0]) begin
            state_d = ST_SETTLE;
            b_d     = 4'd0;
          end else begin
            b_d = 4'd1;
          end
        end
      end
      ST_SETTLE: begin
        if (phase_end) begin
          state_d = ST_SHIFT_LO;
          b_d     = 4'd0;
        end
      end
      ST_SHIFT_LO: begin
        if (hc_q == '0) begin
          shreg_d[b_q] = ~sync2_q;
        end
        if (phase_end) begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          if (b_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            b_d     = b_q + 4'd1;
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_DONE: begin
        // Clear is folded in first so an edge seen in this frame survives.
        hc_d         = '0;
        buttons_d    = shreg_q;
        pressed_d    = (bus.clear_pressed ? 16'h0000 : pressed_q) | (shreg_q & ~buttons_q);
        new_sample_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        hc_d    = '0;
      end
    endcase

    pad_latch_d = (state_d == ST_LATCH);
    pad_clk_d   = (state_d != ST_SHIFT_LO);
  end

  // State register; an asynchronous reset abandons any frame in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hc_q         <= '0;
      poll_q       <= '0;
      b_q          <= 4'd0;
      shreg_q      <= 16'h0000;
      buttons_q    <= 16'h0000;
      pressed_q    <= 16'h0000;
      new_sample_q <= 1'b0;
      pad_latch_q  <= 1'b0;
      pad_clk_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      hc_q         <= hc_d;
      poll_q       <= poll_d;
      b_q          <= b_d;
      shreg_q      <= shreg_d;
      buttons_q    <= buttons_d;
      pressed_q    <= pressed_d;
      new_sample_q <= new_sample_d;
      pad_latch_q  <= pad_latch_d;
      pad_clk_q    <= pad_clk_d;
    end
  end

  assign bus.pad_latch  = pad_latch_q;
  assign bus.pad_clk    = pad_clk_q;
  assign bus.buttons    = buttons_q;
  assign bus.ctrl_word  = {pressed_q, buttons_q};
  assign bus.new_sample = new_sample_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snes_pad_poller.sv
// Purpose : self-checking bench for snes_pad_poller with a small behavioural
//           pad model and a frame-level reference model of buttons/pressed.
module tb_snes_pad_poller;

  localparam int H     = 4;
  localparam int PC    = 16;
  localparam int FRAME = 35 * H + 1;

  logic clock;
  logic reset;

  int checkCount;
  int failCount;

  logic [15:0] padPattern;
  logic [15:0] padShift;
  logic [15:0] expButtons;
  logic [15:0] expPressed;

  snes_pad_poller_if bus();

  snes_pad_poller #(.CLK_DIV(H), .POLL_CYCLES(PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pad model: loads the inverted pattern on latch, shifts on pad_clk rising,
  // fills with released (1) bits like a real pad.
  initial padShift = 16'hFFFF;
  always @(posedge bus.pad_latch or posedge bus.pad_clk) begin
    if (bus.pad_latch) padShift <= ~padPattern;
    else               padShift <= {1'b1, padShift[15:1]};
  end
  assign bus.pad_data = padShift[0];

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Runs one full frame: waits for the latch, measures pin timing, optionally
  // pulses clear in the DONE cycle or drops enable mid-frame, then compares
  // the published word with the frame-level model.
  task automatic applyStimulus(input logic [15:0] pattern, input bit clearInDone,
                               input bit checkGap, input bit dropEnable);
    int n, latchHigh, clkLow, clkFalls, firstLow, nsIdx, busyLow;
    logic prevClk;
    padPattern = pattern;
    n = 0;
    while (bus.pad_latch !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
      if (checkGap && n == 1) checkOutput("newSampleWidth", 32'(bus.new_sample), 32'd0);
    end
    if (bus.pad_latch !== 1'b1) begin
      checkOutput("latchTimeout", 32'd0, 32'd1);
      return;
    end
    if (checkGap) checkOutput("idleGap", 32'(n), 32'(PC));
    latchHigh = 0; clkLow = 0; clkFalls = 0; firstLow = -1; nsIdx = -1; busyLow = 0;
    prevClk = 1'b1;
    for (int idx = 0; idx <= FRAME; idx++) begin
      if (idx > 0) @(negedge clock);
      if (bus.pad_latch) latchHigh++;
      if (!bus.pad_clk) begin
        clkLow++;
        if (firstLow < 0) firstLow = idx;
        if (prevClk) clkFalls++;
      end
      prevClk = bus.pad_clk;
      if (bus.new_sample && nsIdx < 0) nsIdx = idx;
      if (idx < FRAME && !bus.busy) busyLow++;
      if (dropEnable && idx == 50) bus.enable = 1'b0;
      if (idx == FRAME - 1) bus.clear_pressed = clearInDone;
      if (idx == FRAME) bus.clear_pressed = 1'b0;
    end
    if (clearInDone) expPressed = 16'h0000;
    expPressed = expPressed | (pattern & ~expButtons);
    expButtons = pattern;
    checkOutput("latchCycles", 32'(latchHigh), 32'(2 * H));
    checkOutput("firstClkLow", 32'(firstLow), 32'(3 * H));
    checkOutput("clkLowCycles", 32'(clkLow), 32'(16 * H));
    checkOutput("clkPulses", 32'(clkFalls), 32'd16);
    checkOutput("newSampleAt", 32'(nsIdx), 32'(FRAME));
    checkOutput("busyInFrame", 32'(busyLow), 32'd0);
    checkOutput("busyAfter", 32'(bus.busy), 32'd0);
    checkOutput("buttons", 32'(bus.buttons), 32'(expButtons));
    checkOutput("ctrlWord", bus.ctrl_word, {expPressed, expButtons});
  endtask

  // One-cycle clear pulse while idle.
  task automatic pulseClear();
    @(negedge clock);
    bus.clear_pressed = 1'b1;
    @(negedge clock);
    bus.clear_pressed = 1'b0;
    expPressed = 16'h0000;
    checkOutput("clearIdle", bus.ctrl_word, {16'h0000, expButtons});
  endtask

  // Counts latch rising edges and busy cycles over a window.
  task automatic countLatches(input int cycles, output int rises, output int busyCycles);
    logic prev;
    rises = 0;
    busyCycles = 0;
    prev = bus.pad_latch;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (bus.pad_latch && !prev) rises++;
      if (bus.busy) busyCycles++;
      prev = bus.pad_latch;
    end
  endtask

  // Main sequence: power-on reset, directed data/edge/clear/enable cases,
  // randomized frames, then a reset in the middle of a shift.
  initial begin
    logic [15:0] pat;
    int rises, busyCycles, waitCnt;
    checkCount = 0;
    failCount = 0;
    padPattern = 16'h0000;
    expButtons = 16'h0000;
    expPressed = 16'h0000;
    bus.enable = 1'b0;
    bus.clear_pressed = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rstLatch", 32'(bus.pad_latch), 32'd0);
    checkOutput("rstClk", 32'(bus.pad_clk), 32'd1);
    checkOutput("rstCtrl", bus.ctrl_word, 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstNewSample", 32'(bus.new_sample), 32'd0);

    @(negedge clock);
    reset = 1'b1;
    bus.enable = 1'b1;
    applyStimulus(16'hA5C3, 1'b0, 1'b1, 1'b0);
    checkOutput("dataWord", bus.ctrl_word, 32'hA5C3_A5C3);

    // Back-to-back frame: gap and one-wide new_sample checked again.
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0);
    pulseClear();
    applyStimulus(16'h0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0003, 1'b0, 1'b1, 1'b0);
    checkOutput("edgePressed", 32'(bus.ctrl_word[31:16]), 32'h0003);
    pulseClear();
    checkOutput("edgeCleared", bus.ctrl_word, 32'h0000_0003);
    applyStimulus(16'h0003, 1'b0, 1'b0, 1'b0);
    checkOutput("heldNoEdge", bus.ctrl_word, 32'h0000_0003);

    applyStimulus(16'h0007, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0017, 1'b1, 1'b1, 1'b0);
    checkOutput("simulClear", bus.ctrl_word, 32'h0010_0017);

    pat = 16'h0017;
    for (int f = 0; f < 12; f++) begin
      pat = pat ^ (16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 3) == 0) pulseClear();
      applyStimulus(pat, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    end

    // Enable low while idle: no frames at all.
    bus.enable = 1'b0;
    countLatches(1000, rises, busyCycles);
    checkOutput("idleNoLatch", 32'(rises), 32'd0);
    checkOutput("idleNoBusy", 32'(busyCycles), 32'd0);

    // Enable dropped mid-frame: frame completes, then stays idle.
    bus.enable = 1'b1;
    applyStimulus(16'h8421, 1'b0, 1'b0, 1'b1);
    countLatches(300, rises, busyCycles);
    checkOutput("dropNoLatch", 32'(rises), 32'd0);
    checkOutput("dropHold", 32'(bus.buttons), 32'h8421);

    // Reset in the middle of a shift.
    bus.enable = 1'b1;
    padPattern = 16'hFFFF;
    waitCnt = 0;
    while (bus.pad_clk !== 1'b0 && waitCnt < 400) begin
      @(negedge clock);
      waitCnt++;
    end
    checkOutput("shiftReached", 32'(bus.pad_clk), 32'd0);
    #1 reset = 1'b0;
    #1;
    checkOutput("midRstLatch", 32'(bus.pad_latch), 32'd0);
    checkOutput("midRstClk", 32'(bus.pad_clk), 32'd1);
    checkOutput("midRstCtrl", bus.ctrl_word, 32'd0);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    expButtons = 16'h0000;
    expPressed = 16'h0000;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(16'h5A3C, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
